// File: rtl/pio_pkg.sv
// Shared definitions for the PIO shift unit: command codes and the
// shift helpers used by the ISR (merge) and OSR (take) paths.
package pio_pkg;

    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_IN       = 3'd1,
        CMD_OUT      = 3'd2,
        CMD_PUSH     = 3'd3,
        CMD_PULL     = 3'd4,
        CMD_LOAD_ISR = 3'd5,
        CMD_LOAD_OSR = 3'd6
    } cmd_e;

    // Bits shifted out of the OSR plus what remains behind.
    typedef struct packed {
        word_t taken;
        word_t rest;
    } take_t;

    // Mask of the k low bits; computed in 64 bits so k = 32 is safe.
    function automatic logic [63:0] lo_mask(input int unsigned k);
        logic [63:0] m;
        if (k >= 64) m = '1;
        else         m = (64'd1 << k) - 64'd1;
        return m;
    endfunction

    // Shift n bits of data into a dw-bit register from the chosen side.
    function automatic word_t shift_merge(input word_t cur, input word_t data,
                                          input int unsigned n, input logic right,
                                          input int unsigned dw);
        logic [63:0] c;
        logic [63:0] d;
        logic [63:0] r;
        c = {32'd0, cur};
        d = {32'd0, data} & lo_mask(n);
        if (right) r = (c >> n) | (d << (dw - n));
        else       r = (c << n) | d;
        r = r & lo_mask(dw);
        return r[MAX_W-1:0];
    endfunction

    // Remove n bits from a dw-bit register; taken bits are right-justified.
    function automatic take_t shift_take(input word_t cur, input int unsigned n,
                                         input logic right, input int unsigned dw);
        logic [63:0] c;
        logic [63:0] t;
        logic [63:0] r;
        take_t res;
        c = {32'd0, cur} & lo_mask(dw);
        if (right) begin
            t = c & lo_mask(n);
            r = c >> n;
        end else begin
            t = (c >> (dw - n)) & lo_mask(n);
            r = (c << n) & lo_mask(dw);
        end
        res.taken = t[MAX_W-1:0];
        res.rest  = r[MAX_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/pio_shift_unit.sv
// ISR/OSR shift datapath for the PIO state machine: IN/OUT shifting,
// blocking and non-blocking PUSH/PULL, autopush/autopull and stall.
module pio_shift_unit
    import pio_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              penable,
    input  logic              restart,
    input  logic              in_shr,
    input  logic              out_shr,
    input  logic              auto_push,
    input  logic              auto_pull,
    input  logic [CNT_W-1:0]  push_thresh,
    input  logic [CNT_W-1:0]  pull_thresh,
    input  logic [2:0]        cmd,
    input  logic [CNT_W-1:0]  cmd_bits,
    input  logic              cmd_block,
    input  logic              cmd_ifcond,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] x_in,
    input  logic              rx_ready,
    output logic              rx_push,
    output logic [DATA_W-1:0] rx_data,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] isr,
    output logic [DATA_W-1:0] osr,
    output logic [CNT_W-1:0]  isr_count,
    output logic [CNT_W-1:0]  osr_count,
    output logic              stall,
    output logic              rx_overflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    logic              active;
    logic [CNT_W-1:0]  n_bits;
    logic [CNT_W-1:0]  push_t;
    logic [CNT_W-1:0]  pull_t;
    logic [CNT_W:0]    isr_sum;
    logic [CNT_W:0]    osr_sum;
    logic [CNT_W-1:0]  isr_cnt_in;
    logic [CNT_W-1:0]  osr_cnt_out;
    logic              refill;
    word_t             in_merged;
    word_t             out_src;
    take_t             out_take;

    logic [DATA_W-1:0] isr_nxt;
    logic [DATA_W-1:0] osr_nxt;
    logic [CNT_W-1:0]  isr_cnt_nxt;
    logic [CNT_W-1:0]  osr_cnt_nxt;

    // Restart and reset both suppress every strobe combinationally.
    assign active  = reset_n && penable && !restart;

    // Zero encodes a full word for bit counts and thresholds.
    assign n_bits  = (cmd_bits    == '0) ? FULL_CNT : cmd_bits;
    assign push_t  = (push_thresh == '0) ? FULL_CNT : push_thresh;
    assign pull_t  = (pull_thresh == '0) ? FULL_CNT : pull_thresh;

    assign isr_sum     = {1'b0, isr_count} + {1'b0, n_bits};
    assign osr_sum     = {1'b0, osr_count} + {1'b0, n_bits};
    assign isr_cnt_in  = (isr_sum > {1'b0, FULL_CNT}) ? FULL_CNT : isr_sum[CNT_W-1:0];
    assign osr_cnt_out = (osr_sum > {1'b0, FULL_CNT}) ? FULL_CNT : osr_sum[CNT_W-1:0];

    // An OUT on an exhausted OSR shifts from the FIFO head as a fresh word.
    assign refill    = auto_pull && (osr_count >= pull_t);
    assign in_merged = shift_merge(word_t'(isr), word_t'(cmd_data), 32'(n_bits), in_shr, DATA_W);
    assign out_src   = refill ? word_t'(tx_data) : word_t'(osr);
    assign out_take  = shift_take(out_src, 32'(n_bits), out_shr, DATA_W);

    // Command decode: strobes, stall and next register values.
    always_comb begin
        isr_nxt     = isr;
        osr_nxt     = osr;
        isr_cnt_nxt = isr_count;
        osr_cnt_nxt = osr_count;
        stall       = 1'b0;
        rx_push     = 1'b0;
        rx_data     = isr;
        tx_pop      = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        rx_overflow = 1'b0;
        if (active) begin
            unique case (cmd_e'(cmd))
                CMD_IN: begin
                    if (auto_push && (isr_cnt_in >= push_t)) begin
                        // The push and the shift are one atomic step.
                        if (rx_ready) begin
                            rx_push     = 1'b1;
                            rx_data     = in_merged[DATA_W-1:0];
                            isr_nxt     = '0;
                            isr_cnt_nxt = '0;
                        end else begin
                            stall = 1'b1;
                        end
                    end else begin
                        isr_nxt     = in_merged[DATA_W-1:0];
                        isr_cnt_nxt = isr_cnt_in;
                    end
                end
                CMD_OUT: begin
                    if (refill && !tx_valid) begin
                        stall = 1'b1;
                    end else begin
                        tx_pop      = refill;
                        out_valid   = 1'b1;
                        out_data    = out_take.taken[DATA_W-1:0];
                        osr_nxt     = out_take.rest[DATA_W-1:0];
                        osr_cnt_nxt = refill ? n_bits : osr_cnt_out;
                    end
                end
                CMD_PUSH: begin
                    if (cmd_ifcond && (isr_count < push_t)) begin
                        // IfFull not satisfied: completes with no effect.
                    end else if (rx_ready) begin
                        rx_push     = 1'b1;
                        isr_nxt     = '0;
                        isr_cnt_nxt = '0;
                    end else if (cmd_block) begin
                        stall = 1'b1;
                    end else begin
                        rx_overflow = 1'b1;
                        isr_nxt     = '0;
                        isr_cnt_nxt = '0;
                    end
                end
                CMD_PULL: begin
                    if ((cmd_ifcond || auto_pull) && (osr_count < pull_t)) begin
                        // OSR still holds data: completes with no effect.
                    end else if (tx_valid) begin
                        tx_pop      = 1'b1;
                        osr_nxt     = tx_data;
                        osr_cnt_nxt = '0;
                    end else if (cmd_block) begin
                        stall = 1'b1;
                    end else begin
                        osr_nxt     = x_in;
                        osr_cnt_nxt = '0;
                    end
                end
                CMD_LOAD_ISR: begin
                    isr_nxt     = cmd_data;
                    isr_cnt_nxt = '0;
                end
                CMD_LOAD_OSR: begin
                    osr_nxt     = cmd_data;
                    osr_cnt_nxt = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // State registers; an empty OSR (count = DATA_W) makes the first OUT autopull.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            isr       <= '0;
            osr       <= '0;
            isr_count <= '0;
            osr_count <= FULL_CNT;
        end else if (restart) begin
            isr       <= '0;
            osr       <= '0;
            isr_count <= '0;
            osr_count <= FULL_CNT;
        end else if (active && !stall) begin
            isr       <= isr_nxt;
            osr       <= osr_nxt;
            isr_count <= isr_cnt_nxt;
            osr_count <= osr_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pio_shift_unit.sv
// Self-checking bench for pio_shift_unit: directed scenarios followed by
// randomized commands, all compared against an arithmetic reference model.
module tb_pio_shift_unit;

    localparam int DW = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          penable, restart, in_shr, out_shr, auto_push, auto_pull;
    logic [CW-1:0] push_thresh, pull_thresh, cmd_bits;
    logic [2:0]    cmd;
    logic          cmd_block, cmd_ifcond;
    logic [DW-1:0] cmd_data, x_in, tx_data;
    logic          rx_ready, tx_valid;
    logic          rx_push, tx_pop, out_valid, stall, rx_overflow;
    logic [DW-1:0] rx_data, out_data, isr, osr;
    logic [CW-1:0] isr_count, osr_count;

    always #5 clk = ~clk;

    pio_shift_unit #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .penable(penable), .restart(restart),
        .in_shr(in_shr), .out_shr(out_shr), .auto_push(auto_push), .auto_pull(auto_pull),
        .push_thresh(push_thresh), .pull_thresh(pull_thresh), .cmd(cmd),
        .cmd_bits(cmd_bits), .cmd_block(cmd_block), .cmd_ifcond(cmd_ifcond),
        .cmd_data(cmd_data), .x_in(x_in), .rx_ready(rx_ready), .rx_push(rx_push),
        .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_pop(tx_pop),
        .out_valid(out_valid), .out_data(out_data), .isr(isr), .osr(osr),
        .isr_count(isr_count), .osr_count(osr_count), .stall(stall),
        .rx_overflow(rx_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (plain integers).
    longint unsigned m_isr, m_osr, nx_isr, nx_osr;
    int m_ic, m_oc, nx_ic, nx_oc;
    // Expected combinational outputs for the current cycle.
    logic e_stall, e_rxp, e_txp, e_ov, e_ovf;
    longint unsigned e_rxd, e_outd;
    // Observed combinational outputs, sampled mid-cycle.
    logic o_stall, o_rxp, o_txp, o_ov, o_ovf;
    logic [DW-1:0] o_rxd, o_outd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned p2(input int k);
        return 64'd1 << k;
    endfunction

    function automatic int min32(input int a);
        return (a > DW) ? DW : a;
    endfunction

    task automatic model_reset();
        m_isr = 0; m_osr = 0; m_ic = 0; m_oc = DW;
    endtask

    // Reference behaviour from the command rules, using powers of two.
    task automatic model_eval();
        int n, tp, tl, cnt;
        longint unsigned d, nv, src, modw;
        modw = p2(DW);
        n  = (cmd_bits == 0) ? DW : int'(cmd_bits);
        tp = (push_thresh == 0) ? DW : int'(push_thresh);
        tl = (pull_thresh == 0) ? DW : int'(pull_thresh);
        e_stall = 0; e_rxp = 0; e_txp = 0; e_ov = 0; e_ovf = 0; e_rxd = 0; e_outd = 0;
        nx_isr = m_isr; nx_osr = m_osr; nx_ic = m_ic; nx_oc = m_oc;
        if (!reset_n || restart) begin
            nx_isr = 0; nx_osr = 0; nx_ic = 0; nx_oc = DW;
        end else if (penable) begin
            case (cmd)
                3'd1: begin
                    d = longint'(cmd_data) % p2(n);
                    if (!in_shr) nv = (m_isr * p2(n) + d) % modw;
                    else         nv = m_isr / p2(n) + d * p2(DW - n);
                    cnt = min32(m_ic + n);
                    if (auto_push && cnt >= tp) begin
                        if (rx_ready) begin
                            e_rxp = 1; e_rxd = nv; nx_isr = 0; nx_ic = 0;
                        end else e_stall = 1;
                    end else begin
                        nx_isr = nv; nx_ic = cnt;
                    end
                end
                3'd2: begin
                    src = m_osr; cnt = min32(m_oc + n);
                    if (auto_pull && m_oc >= tl) begin
                        if (tx_valid) begin
                            e_txp = 1; src = longint'(tx_data); cnt = n;
                        end else e_stall = 1;
                    end
                    if (!e_stall) begin
                        e_ov = 1;
                        if (!out_shr) begin
                            e_outd = src / p2(DW - n);
                            nx_osr = (src * p2(n)) % modw;
                        end else begin
                            e_outd = src % p2(n);
                            nx_osr = src / p2(n);
                        end
                        nx_oc = cnt;
                    end
                end
                3'd3: begin
                    if (cmd_ifcond && m_ic < tp) begin
                    end else if (rx_ready) begin
                        e_rxp = 1; e_rxd = m_isr; nx_isr = 0; nx_ic = 0;
                    end else if (cmd_block) e_stall = 1;
                    else begin
                        e_ovf = 1; nx_isr = 0; nx_ic = 0;
                    end
                end
                3'd4: begin
                    if ((cmd_ifcond || auto_pull) && m_oc < tl) begin
                    end else if (tx_valid) begin
                        e_txp = 1; nx_osr = longint'(tx_data); nx_oc = 0;
                    end else if (cmd_block) e_stall = 1;
                    else begin
                        nx_osr = longint'(x_in); nx_oc = 0;
                    end
                end
                3'd5: begin nx_isr = longint'(cmd_data); nx_ic = 0; end
                3'd6: begin nx_osr = longint'(cmd_data); nx_oc = 0; end
                default: begin end
            endcase
        end
    endtask

    // One clock: compare strobes mid-cycle, then registers just after the edge.
    task automatic cycle();
        @(negedge clk);
        model_eval();
        o_stall = stall; o_rxp = rx_push; o_txp = tx_pop; o_ov = out_valid;
        o_ovf = rx_overflow; o_rxd = rx_data; o_outd = out_data;
        check("stall", 64'(o_stall), 64'(e_stall));
        check("rx_push", 64'(o_rxp), 64'(e_rxp));
        check("tx_pop", 64'(o_txp), 64'(e_txp));
        check("out_valid", 64'(o_ov), 64'(e_ov));
        check("rx_overflow", 64'(o_ovf), 64'(e_ovf));
        if (e_rxp) check("rx_data", 64'(o_rxd), e_rxd);
        if (e_ov)  check("out_data", 64'(o_outd), e_outd);
        @(posedge clk);
        #1;
        m_isr = nx_isr; m_osr = nx_osr; m_ic = nx_ic; m_oc = nx_oc;
        check("isr", 64'(isr), m_isr);
        check("osr", 64'(osr), m_osr);
        check("isr_count", 64'(isr_count), 64'(m_ic));
        check("osr_count", 64'(osr_count), 64'(m_oc));
    endtask

    task automatic idle_inputs();
        penable = 1; restart = 0; in_shr = 0; out_shr = 0; auto_push = 0; auto_pull = 0;
        push_thresh = 0; pull_thresh = 0; cmd = 0; cmd_bits = 0; cmd_block = 0;
        cmd_ifcond = 0; cmd_data = 0; x_in = 0; rx_ready = 1; tx_valid = 0; tx_data = 0;
    endtask

    task automatic do_restart();
        idle_inputs();
        restart = 1;
        cycle();
        restart = 0;
    endtask

    initial begin
        logic [DW-1:0] bytes4 [4];
        bytes4[0] = 32'hAA; bytes4[1] = 32'hBB; bytes4[2] = 32'hCC; bytes4[3] = 32'hDD;

        idle_inputs();
        reset_n = 0;
        model_reset();
        #12;
        check("reset_isr", 64'(isr), 64'd0);
        check("reset_osr_count", 64'(osr_count), 64'd32);
        check("reset_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        reset_n = 1;

        // Autopush of four left-shifted bytes.
        auto_push = 1; push_thresh = 6'd32; cmd = 3'd1; cmd_bits = 6'd8;
        for (int i = 0; i < 4; i++) begin
            cmd_data = bytes4[i];
            cycle();
        end
        check("ap_push", 64'(o_rxp), 64'd1);
        check("ap_data", 64'(o_rxd), 64'hAABBCCDD);
        check("ap_isr", 64'(isr), 64'd0);
        check("ap_count", 64'(isr_count), 64'd0);

        // Same with RX full on the fourth IN: stall until it drains.
        for (int i = 0; i < 3; i++) begin
            cmd_data = bytes4[i];
            cycle();
        end
        cmd_data = bytes4[3]; rx_ready = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("ap_stall", 64'(o_stall), 64'd1);
            check("ap_hold_count", 64'(isr_count), 64'd24);
        end
        rx_ready = 1;
        cycle();
        check("ap_release_push", 64'(o_rxp), 64'd1);
        check("ap_release_data", 64'(o_rxd), 64'hAABBCCDD);

        // First OUT after restart autopulls from TX.
        do_restart();
        out_shr = 1; auto_pull = 1; pull_thresh = 6'd32; cmd = 3'd2; cmd_bits = 6'd4;
        tx_valid = 1; tx_data = 32'h12345678;
        cycle();
        check("out_pop", 64'(o_txp), 64'd1);
        check("out_data4", 64'(o_outd), 64'h8);
        check("out_osr", 64'(osr), 64'h01234567);
        check("out_count", 64'(osr_count), 64'd4);

        // OUT on empty TX stalls for five cycles.
        do_restart();
        out_shr = 1; auto_pull = 1; cmd = 3'd2; cmd_bits = 6'd8; tx_valid = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("empty_stall", 64'(o_stall), 64'd1);
            check("empty_no_valid", 64'(o_ov), 64'd0);
        end
        tx_valid = 1; tx_data = 32'hCAFE0042;
        cycle();
        check("empty_release", 64'(o_outd), 64'h42);

        // Non-blocking PULL on empty TX loads X.
        do_restart();
        cmd = 3'd4; tx_valid = 0; x_in = 32'hDEADBEEF;
        cycle();
        check("nb_pull_osr", 64'(osr), 64'hDEADBEEF);
        check("nb_pull_count", 64'(osr_count), 64'd0);
        check("nb_pull_pop", 64'(o_txp), 64'd0);

        // Non-blocking PUSH on full RX drops the word.
        idle_inputs();
        cmd = 3'd5; cmd_data = 32'h5A5A1234;
        cycle();
        cmd = 3'd3; rx_ready = 0;
        cycle();
        check("nb_push_ovf", 64'(o_ovf), 64'd1);
        check("nb_push_isr", 64'(isr), 64'd0);

        // PUSH IfFull below threshold does nothing.
        idle_inputs();
        cmd = 3'd1; cmd_bits = 6'd8; cmd_data = 32'h3C;
        cycle();
        cmd = 3'd3; cmd_ifcond = 1; push_thresh = 6'd16;
        cycle();
        check("iffull_nop", 64'(o_rxp), 64'd0);
        check("iffull_isr", 64'(isr), 64'h3C);

        // Restart during a blocking PULL stall.
        idle_inputs();
        cmd = 3'd6; cmd_data = 32'h1;
        cycle();
        cmd = 3'd4; cmd_block = 1; tx_valid = 0;
        cycle();
        check("bpull_stall", 64'(o_stall), 64'd1);
        restart = 1;
        cycle();
        check("restart_stall", 64'(o_stall), 64'd0);
        check("restart_osr_count", 64'(osr_count), 64'd32);
        restart = 0;

        // Randomized command stream.
        for (int i = 0; i < 3000; i++) begin
            penable     = ($urandom_range(0, 3) != 0);
            restart     = ($urandom_range(0, 99) == 0);
            reset_n     = !(i == 1500);
            in_shr      = 1'($urandom);
            out_shr     = 1'($urandom);
            auto_push   = 1'($urandom);
            auto_pull   = 1'($urandom);
            push_thresh = 6'($urandom_range(0, 32));
            pull_thresh = 6'($urandom_range(0, 32));
            cmd         = 3'($urandom_range(0, 7));
            cmd_bits    = 6'($urandom_range(0, 32));
            cmd_block   = 1'($urandom);
            cmd_ifcond  = 1'($urandom);
            cmd_data    = $urandom;
            x_in        = $urandom;
            tx_data     = $urandom;
            rx_ready    = ($urandom_range(0, 3) != 0);
            tx_valid    = ($urandom_range(0, 3) != 0);
            cycle();
        end
        reset_n = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
